spi_slave_if: RTL



---
 rtl/spi_pkg.sv | 41 ++++
 rtl/spi_shift_reg.sv | 48 ++++
 rtl/spi_slave_if.sv | 169 ++++++++++++++++
 3 files changed

// File: rtl/spi_pkg.sv
// Shared state encodings, command codes and word layout for the SPI slave front end.
package spi_pkg;

  localparam int unsigned DATA_W_DEF = 8;

  localparam logic [1:0] CMD_WR_ADDR = 2'b00;
  localparam logic [1:0] CMD_WR_DATA = 2'b01;
  localparam logic [1:0] CMD_RD_ADDR = 2'b10;
  localparam logic [1:0] CMD_RD_DATA = 2'b11;

  typedef enum logic [2:0] {
    IDLE,
    CHK_CMD,
    WRITE,
    READ_ADD,
    READ_DATA
  } state_e;

  // Sub-phases of READ_DATA: receive, one ignored cycle, wait for RAM, transmit, done.
  typedef enum logic [2:0] {
    RD_RX,
    RD_GAP,
    RD_WAIT,
    RD_TX,
    RD_DONE
  } rd_phase_e;

  typedef struct packed {
    logic [1:0]            cmd;
    logic [DATA_W_DEF-1:0] payload;
  } spi_word_t;

  function automatic spi_word_t make_word(input logic [1:0] cmd,
                                          input logic [DATA_W_DEF-1:0] payload);
    spi_word_t w;
    w.cmd     = cmd;
    w.payload = payload;
    return w;
  endfunction

endpackage

// File: rtl/spi_shift_reg.sv
// Shift register with parallel load and bit counter, shared by the RX and TX paths.
module spi_shift_reg #(
  parameter int unsigned W     = 10,
  parameter int unsigned CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr_i,
  input  logic             load_i,
  input  logic [W-1:0]     load_data_i,
  input  logic             shift_i,
  input  logic             bit_i,
  output logic [W-1:0]     data_o,
  output logic [CNT_W-1:0] cnt_o
);

  logic [W-1:0]     data_q, data_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Clear only resets the counter; data is fully overwritten by the next frame.
  always_comb begin
    data_d = data_q;
    cnt_d  = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (load_i) begin
      data_d = load_data_i;
      cnt_d  = '0;
    end else if (shift_i) begin
      data_d = {data_q[W-2:0], bit_i};
      cnt_d  = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_q <= '0;
      cnt_q  <= '0;
    end else begin
      data_q <= data_d;
      cnt_q  <= cnt_d;
    end
  end

  assign data_o = data_q;
  assign cnt_o  = cnt_q;

endmodule

// File: rtl/spi_slave_if.sv
// SPI slave front end: deserialises 10-bit command words and serialises RAM read data.
// Optional SPI_FRAME_ERR_EN adds a frame_err pulse for frames aborted by SS_n.
module spi_slave_if
  import spi_pkg::*;
#(
  parameter int unsigned DATA_W = DATA_W_DEF,
  parameter int unsigned CNT_W  = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              SS_n,
  input  logic              MOSI,
  output logic              MISO,
  output logic [DATA_W+1:0] rx_data,
  output logic              rx_valid,
  input  logic [DATA_W-1:0] tx_data,
  input  logic              tx_valid
`ifdef SPI_FRAME_ERR_EN
  ,
  output logic              frame_err
`endif
);

  localparam int unsigned FRAME_W = DATA_W + 2;

  state_e           state_q, state_d;
  rd_phase_e        phase_q, phase_d;
  logic             rd_seen_q, rd_seen_d;
  logic             miso_d;
  logic [FRAME_W-1:0] rx_data_d;
  logic             rx_valid_d;

  logic               sr_clr, sr_load, sr_shift;
  logic [FRAME_W-1:0] sr_data;
  logic [CNT_W-1:0]   sr_cnt;
  logic               rx_last, rx_done, tx_last;

  spi_shift_reg #(
    .W     (FRAME_W),
    .CNT_W (CNT_W)
  ) u_sr (
    .clk         (clk),
    .rst_n       (rst_n),
    .clr_i       (sr_clr),
    .load_i      (sr_load),
    .load_data_i ({tx_data, 2'b00}),
    .shift_i     (sr_shift),
    .bit_i       (MOSI),
    .data_o      (sr_data),
    .cnt_o       (sr_cnt)
  );

  assign rx_last = (sr_cnt == CNT_W'(FRAME_W - 1));
  assign rx_done = (sr_cnt == CNT_W'(FRAME_W));
  assign tx_last = (sr_cnt == CNT_W'(DATA_W - 1));

  // Next-state and output decode; SS_n high aborts from any state.
  always_comb begin
    state_d    = state_q;
    phase_d    = phase_q;
    rd_seen_d  = rd_seen_q;
    rx_data_d  = rx_data;
    rx_valid_d = 1'b0;
    miso_d     = 1'b0;
    sr_clr     = 1'b0;
    sr_load    = 1'b0;
    sr_shift   = 1'b0;
    if (SS_n) begin
      state_d = IDLE;
      phase_d = RD_RX;
      sr_clr  = 1'b1;
    end else begin
      unique case (state_q)
        IDLE: begin
          state_d = CHK_CMD;
          phase_d = RD_RX;
          sr_clr  = 1'b1;
        end
        CHK_CMD: begin
          sr_shift = 1'b1;
          if (!MOSI)          state_d = WRITE;
          else if (rd_seen_q) state_d = READ_DATA;
          else                state_d = READ_ADD;
        end
        WRITE, READ_ADD: begin
          if (!rx_done) begin
            sr_shift = 1'b1;
            if (rx_last) begin
              rx_valid_d = 1'b1;
              rx_data_d  = {sr_data[FRAME_W-2:0], MOSI};
              if (state_q == READ_ADD) rd_seen_d = 1'b1;
            end
          end
        end
        READ_DATA: begin
          case (phase_q)
            RD_RX: begin
              sr_shift = 1'b1;
              if (rx_last) begin
                rx_valid_d = 1'b1;
                rx_data_d  = {sr_data[FRAME_W-2:0], MOSI};
                phase_d    = RD_GAP;
              end
            end
            // tx_valid seen alongside rx_valid may be stale from the previous read.
            RD_GAP: phase_d = RD_WAIT;
            RD_WAIT: begin
              if (tx_valid) begin
                sr_load = 1'b1;
                phase_d = RD_TX;
              end
            end
            RD_TX: begin
              sr_shift = 1'b1;
              miso_d   = sr_data[FRAME_W-1];
              if (tx_last) begin
                phase_d   = RD_DONE;
                rd_seen_d = 1'b0;
              end
            end
            default: phase_d = phase_q;
          endcase
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      phase_q   <= RD_RX;
      rd_seen_q <= 1'b0;
      MISO      <= 1'b0;
      rx_data   <= '0;
      rx_valid  <= 1'b0;
    end else begin
      state_q   <= state_d;
      phase_q   <= phase_d;
      rd_seen_q <= rd_seen_d;
      MISO      <= miso_d;
      rx_data   <= rx_data_d;
      rx_valid  <= rx_valid_d;
    end
  end

`ifdef SPI_FRAME_ERR_EN
  logic frame_open;
  logic frame_err_d;

  // A frame is open until its word is issued, or until TX bit 0 for a read-data frame.
  always_comb begin
    frame_open = 1'b0;
    case (state_q)
      CHK_CMD:         frame_open = 1'b1;
      WRITE, READ_ADD: frame_open = !rx_done;
      READ_DATA:       frame_open = (phase_q != RD_DONE);
      default:         frame_open = 1'b0;
    endcase
    frame_err_d = SS_n && frame_open;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) frame_err <= 1'b0;
    else        frame_err <= frame_err_d;
  end
`endif

endmodule
